// File: rtl/switch_alloc_rr_if.sv
// ---------------------------------------------------------------------------
// switch_alloc_rr_if
//
// Bundle of the signals between the router input FIFOs, the downstream links
// and the switch allocator / crossbar.
//
// Signals (master = FIFO/link side, slave = allocator side):
//   in_label   [NPORTS*NPORTS]   per-input one-hot requested output
//   in_data    [NPORTS*DATASIZE] head flit of each input FIFO
//   out_full   [NPORTS]          downstream buffer full, per output
//   in_ready   [NPORTS]          pop strobe back to input FIFO i
//   out_valid  [NPORTS]          registered flit-valid per output
//   out_data   [NPORTS*DATASIZE] registered flit per output
//   out_lock   [NPORTS]          output currently locked to a packet
// ---------------------------------------------------------------------------
interface switch_alloc_rr_if #(
    parameter int NPORTS   = 5,
    parameter int DATASIZE = 40
);
    logic [NPORTS*NPORTS-1:0]   in_label;
    logic [NPORTS*DATASIZE-1:0] in_data;
    logic [NPORTS-1:0]          out_full;
    logic [NPORTS-1:0]          in_ready;
    logic [NPORTS-1:0]          out_valid;
    logic [NPORTS*DATASIZE-1:0] out_data;
    logic [NPORTS-1:0]          out_lock;

    modport master (
        output in_label,
        output in_data,
        output out_full,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_lock
    );

    modport slave (
        input  in_label,
        input  in_data,
        input  out_full,
        output in_ready,
        output out_valid,
        output out_data,
        output out_lock
    );
endinterface

// File: rtl/switch_alloc_rr.sv
// ---------------------------------------------------------------------------
// switch_alloc_rr
//
// Switch allocator and crossbar for the mesh NoC router. Every output port
// owns a round-robin arbiter over the inputs that request it, plus an
// optional wormhole lock that keeps the output dedicated to one input from
// a head flit until the matching tail flit.
//
// Parameters:
//   NPORTS    number of router ports (2..5, L N E S W order)
//   DATASIZE  flit width; flit type lives in bits [1:0]
//   LOCK_EN   1 = wormhole packet lock per output, 0 = per-flit arbitration
//
// Ports:
//   clk    router clock
//   rst_n  asynchronous active-low reset
//   bus    switch_alloc_rr_if.slave
//            in_label/in_data/out_full in, in_ready (combinational),
//            out_valid/out_data (registered), out_lock (registered state)
// ---------------------------------------------------------------------------
module switch_alloc_rr #(
    parameter int NPORTS   = 5,
    parameter int DATASIZE = 40,
    parameter int LOCK_EN  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    switch_alloc_rr_if.slave bus
);

    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    localparam logic [1:0] TYPE_HEAD = 2'b01;
    localparam logic [1:0] TYPE_TAIL = 2'b11;

    typedef enum logic {
        IDLE,
        LOCKED
    } lock_state_t;

    lock_state_t             state     [NPORTS];
    logic [PW-1:0]           ptr       [NPORTS];
    logic [PW-1:0]           owner     [NPORTS];

    logic [NPORTS-1:0]       req_first [NPORTS];
    logic [NPORTS-1:0]       req       [NPORTS];
    logic [NPORTS-1:0]       grant;
    logic [PW-1:0]           win       [NPORTS];
    logic [1:0]              win_type  [NPORTS];
    logic [NPORTS-1:0]       ready;
    logic [NPORTS-1:0]       lock_flag;

    logic [NPORTS-1:0]          out_valid_q;
    logic [NPORTS*DATASIZE-1:0] out_data_q;

    // Pointer increment modulo NPORTS; NPORTS need not be a power of two.
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
        if (int'(v) == NPORTS - 1) begin
            return '0;
        end
        return v + PW'(1);
    endfunction

    // Request decode: keep only the lowest set bit of each input label, so a
    // malformed multi-hot label still requests exactly one output. The result
    // is then transposed so each output sees a vector indexed by input.
    always_comb begin
        for (int i = 0; i < NPORTS; i++) begin
            req_first[i] = bus.in_label[i*NPORTS +: NPORTS]
                         & (~bus.in_label[i*NPORTS +: NPORTS] + NPORTS'(1));
        end
        for (int j = 0; j < NPORTS; j++) begin
            req[j] = '0;
            for (int i = 0; i < NPORTS; i++) begin
                req[j][i] = req_first[i][j];
            end
        end
    end

    // Per-output arbitration: walk the inputs starting at the priority
    // pointer and take the first eligible requester. While locked only the
    // owning input is eligible. A full downstream buffer or an asserted reset
    // suppresses the grant but not the search itself.
    always_comb begin
        logic found;
        int   idx;
        found = 1'b0;
        idx   = 0;
        for (int j = 0; j < NPORTS; j++) begin
            found    = 1'b0;
            win[j]   = '0;
            for (int k = 0; k < NPORTS; k++) begin
                idx = int'(ptr[j]) + k;
                if (idx >= NPORTS) begin
                    idx = idx - NPORTS;
                end
                if (!found && req[j][idx] &&
                    (state[j] != LOCKED || owner[j] == PW'(idx))) begin
                    found  = 1'b1;
                    win[j] = PW'(idx);
                end
            end
            grant[j]    = found && !bus.out_full[j] && rst_n;
            win_type[j] = bus.in_data[int'(win[j])*DATASIZE +: 2];
        end
    end

    // Pop strobes: each input requests at most one output, so OR-ing the
    // per-output grants back onto inputs never produces a double pop.
    always_comb begin
        ready = '0;
        for (int j = 0; j < NPORTS; j++) begin
            if (grant[j]) begin
                ready[win[j]] = 1'b1;
            end
        end
    end

    // Lock state is exposed directly; with LOCK_EN=0 no output ever leaves
    // IDLE so this stays zero.
    always_comb begin
        for (int j = 0; j < NPORTS; j++) begin
            lock_flag[j] = (state[j] == LOCKED);
        end
    end

    // Output registers, priority pointers and the wormhole lock FSM.
    // A head flit granted in IDLE claims the output without moving the
    // pointer; the pointer moves past the owner only when its tail leaves,
    // so the whole packet counts as a single round-robin turn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= '0;
            out_data_q  <= '0;
            for (int j = 0; j < NPORTS; j++) begin
                state[j] <= IDLE;
                ptr[j]   <= '0;
                owner[j] <= '0;
            end
        end else begin
            for (int j = 0; j < NPORTS; j++) begin
                out_valid_q[j] <= grant[j];
                if (grant[j]) begin
                    out_data_q[j*DATASIZE +: DATASIZE] <=
                        bus.in_data[int'(win[j])*DATASIZE +: DATASIZE];
                    if (LOCK_EN == 0) begin
                        ptr[j] <= wrap_inc(win[j]);
                    end else begin
                        case (state[j])
                            IDLE: begin
                                if (win_type[j] == TYPE_HEAD) begin
                                    state[j] <= LOCKED;
                                    owner[j] <= win[j];
                                end else begin
                                    ptr[j] <= wrap_inc(win[j]);
                                end
                            end
                            LOCKED: begin
                                if (win_type[j] == TYPE_TAIL) begin
                                    state[j] <= IDLE;
                                    ptr[j]   <= wrap_inc(owner[j]);
                                end
                            end
                            default: begin
                                state[j] <= IDLE;
                            end
                        endcase
                    end
                end
            end
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_lock  = lock_flag;

endmodule

// File: tb/tb_switch_alloc_rr.sv
// ---------------------------------------------------------------------------
// tb_switch_alloc_rr
//
// Directed bench for switch_alloc_rr. Two allocators share one stimulus: one
// with the wormhole lock enabled and one with it disabled. Expected outputs
// are queued when a cycle is driven and compared one cycle later.
// ---------------------------------------------------------------------------
module tb_switch_alloc_rr;

    localparam int NP = 5;
    localparam int DS = 40;

    localparam logic [1:0] T_SINGLE = 2'b00;
    localparam logic [1:0] T_HEAD   = 2'b01;
    localparam logic [1:0] T_BODY   = 2'b10;
    localparam logic [1:0] T_TAIL   = 2'b11;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    switch_alloc_rr_if #(.NPORTS(NP), .DATASIZE(DS)) bus_lk ();
    switch_alloc_rr_if #(.NPORTS(NP), .DATASIZE(DS)) bus_nl ();

    assign bus_nl.in_label = bus_lk.in_label;
    assign bus_nl.in_data  = bus_lk.in_data;
    assign bus_nl.out_full = bus_lk.out_full;

    switch_alloc_rr #(.NPORTS(NP), .DATASIZE(DS), .LOCK_EN(1)) dut_lk (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_lk.slave)
    );

    switch_alloc_rr #(.NPORTS(NP), .DATASIZE(DS), .LOCK_EN(0)) dut_nl (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_nl.slave)
    );

    typedef struct {
        string             tag;
        logic [NP-1:0]     mask_lk;
        logic [NP*DS-1:0]  data_lk;
        bit                use_nl;
        logic [NP-1:0]     mask_nl;
        logic [NP*DS-1:0]  data_nl;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    logic [NP*NP-1:0] cur_lab;
    logic [NP*DS-1:0] cur_dat;
    logic [NP-1:0]    cur_full;

    function automatic logic [DS-1:0] flit(input logic [3:0] src, input logic [3:0] dst,
                                           input logic [21:0] payload, input logic [1:0] ftype);
        return {src, dst, 8'h00, payload, ftype};
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic clearReq();
        cur_lab  = '0;
        cur_dat  = '0;
        cur_full = '0;
    endtask

    task automatic setReq(input int i, input int j, input logic [DS-1:0] f);
        cur_lab[i*NP + j]    = 1'b1;
        cur_dat[i*DS +: DS] = f;
    endtask

    task automatic drive();
        bus_lk.in_label = cur_lab;
        bus_lk.in_data  = cur_dat;
        bus_lk.out_full = cur_full;
    endtask

    // Granted input i lands on the output named by the lowest set bit of its label.
    task automatic buildExp(input logic [NP-1:0] rdy, output logic [NP-1:0] mask,
                            output logic [NP*DS-1:0] dat);
        bit found;
        mask = '0;
        dat  = '0;
        for (int i = 0; i < NP; i++) begin
            if (rdy[i]) begin
                found = 1'b0;
                for (int j = 0; j < NP; j++) begin
                    if (!found && cur_lab[i*NP + j]) begin
                        found              = 1'b1;
                        mask[j]            = 1'b1;
                        dat[j*DS +: DS] = cur_dat[i*DS +: DS];
                    end
                end
            end
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL scoreboard_empty observed 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            chk({e.tag, "/lk_out_valid"}, bus_lk.out_valid, e.mask_lk);
            for (int j = 0; j < NP; j++) begin
                if (e.mask_lk[j]) begin
                    chk($sformatf("%s/lk_out_data%0d", e.tag, j),
                        bus_lk.out_data[j*DS +: DS], e.data_lk[j*DS +: DS]);
                end
            end
            if (e.use_nl) begin
                chk({e.tag, "/nl_out_valid"}, bus_nl.out_valid, e.mask_nl);
                for (int j = 0; j < NP; j++) begin
                    if (e.mask_nl[j]) begin
                        chk($sformatf("%s/nl_out_data%0d", e.tag, j),
                            bus_nl.out_data[j*DS +: DS], e.data_nl[j*DS +: DS]);
                    end
                end
            end
        end
    endtask

    // One cycle: entered #1 after a rising edge, leaves #1 after the next one.
    task automatic applyStimulus(input string tag, input logic [NP-1:0] exp_ready,
                                 input logic [NP-1:0] exp_lock, input bit use_nl,
                                 input logic [NP-1:0] exp_ready_nl);
        exp_t e;
        drive();
        #3;
        chk({tag, "/lk_in_ready"}, bus_lk.in_ready, exp_ready);
        chk({tag, "/lk_out_lock"}, bus_lk.out_lock, exp_lock);
        chk({tag, "/nl_out_lock"}, bus_nl.out_lock, '0);
        if (use_nl) begin
            chk({tag, "/nl_in_ready"}, bus_nl.in_ready, exp_ready_nl);
        end
        e.tag    = tag;
        e.use_nl = use_nl;
        buildExp(exp_ready, e.mask_lk, e.data_lk);
        buildExp(exp_ready_nl, e.mask_nl, e.data_nl);
        sb.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    logic [NP-1:0] rr_order [6];

    initial begin
        $display("[TB] start");
        clearReq();
        setReq(0, 2, flit(4'd0, 4'd2, 22'h3F, T_SINGLE));
        drive();

        // Reset state, with a live request that must not pop its FIFO.
        @(posedge clk);
        #2;
        chk("rst/in_ready",  bus_lk.in_ready,  '0);
        chk("rst/out_valid", bus_lk.out_valid, '0);
        chk("rst/out_data",  bus_lk.out_data,  '0);
        chk("rst/out_lock",  bus_lk.out_lock,  '0);
        chk("rst/nl_in_ready", bus_nl.in_ready, '0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        clearReq();
        drive();
        @(posedge clk);
        #1;

        // Single request; then pointer of output 2 must sit at 1.
        clearReq();
        setReq(0, 2, flit(4'd0, 4'd2, 22'hA5, T_SINGLE));
        applyStimulus("single", 5'b00001, 5'b00000, 1'b1, 5'b00001);
        clearReq();
        setReq(0, 2, flit(4'd0, 4'd2, 22'h11, T_SINGLE));
        setReq(1, 2, flit(4'd1, 4'd2, 22'h12, T_SINGLE));
        applyStimulus("ptr_after_single", 5'b00010, 5'b00000, 1'b1, 5'b00010);
        clearReq();
        setReq(0, 2, flit(4'd0, 4'd2, 22'h13, T_SINGLE));
        applyStimulus("ptr_wrap", 5'b00001, 5'b00000, 1'b1, 5'b00001);

        // Round robin among inputs 0, 1, 3 on output 4.
        rr_order[0] = 5'b00001;
        rr_order[1] = 5'b00010;
        rr_order[2] = 5'b01000;
        rr_order[3] = 5'b00001;
        rr_order[4] = 5'b00010;
        rr_order[5] = 5'b01000;
        for (int c = 0; c < 6; c++) begin
            clearReq();
            setReq(0, 4, flit(4'd0, 4'd4, 22'(32'h100 + c), T_SINGLE));
            setReq(1, 4, flit(4'd1, 4'd4, 22'(32'h200 + c), T_SINGLE));
            setReq(3, 4, flit(4'd3, 4'd4, 22'(32'h300 + c), T_SINGLE));
            applyStimulus($sformatf("rr%0d", c), rr_order[c], 5'b00000, 1'b1, rr_order[c]);
        end

        // Parallel traffic on disjoint outputs.
        clearReq();
        setReq(0, 1, flit(4'd0, 4'd1, 22'h0A01, T_SINGLE));
        setReq(1, 2, flit(4'd1, 4'd2, 22'h0A12, T_SINGLE));
        setReq(2, 0, flit(4'd2, 4'd0, 22'h0A20, T_SINGLE));
        applyStimulus("parallel", 5'b00111, 5'b00000, 1'b1, 5'b00111);

        // Backpressure on output 3.
        for (int c = 0; c < 3; c++) begin
            clearReq();
            setReq(2, 3, flit(4'd2, 4'd3, 22'h0B23, T_SINGLE));
            cur_full = 5'b01000;
            applyStimulus($sformatf("bp_full%0d", c), 5'b00000, 5'b00000, 1'b1, 5'b00000);
        end
        clearReq();
        setReq(2, 3, flit(4'd2, 4'd3, 22'h0B23, T_SINGLE));
        applyStimulus("bp_release", 5'b00100, 5'b00000, 1'b1, 5'b00100);

        // Multi-hot label: only the lowest requested output (1) is served.
        clearReq();
        cur_lab[3*NP + 1] = 1'b1;
        cur_lab[3*NP + 4] = 1'b1;
        cur_dat[3*DS +: DS] = flit(4'd3, 4'd1, 22'h0C31, T_SINGLE);
        applyStimulus("multi_label", 5'b01000, 5'b00000, 1'b1, 5'b01000);

        // Wormhole lock on output 2 (pointer at 2 after the parallel step).
        clearReq();
        setReq(0, 2, flit(4'd0, 4'd2, 22'h0D00, T_SINGLE));
        applyStimulus("lock_pre", 5'b00001, 5'b00000, 1'b1, 5'b00001);
        clearReq();
        setReq(0, 2, flit(4'd0, 4'd2, 22'h0D01, T_SINGLE));
        setReq(1, 2, flit(4'd1, 4'd2, 22'h0D10, T_HEAD));
        applyStimulus("lock_head", 5'b00010, 5'b00000, 1'b1, 5'b00010);
        clearReq();
        setReq(0, 2, flit(4'd0, 4'd2, 22'h0D01, T_SINGLE));
        setReq(1, 2, flit(4'd1, 4'd2, 22'h0D11, T_BODY));
        applyStimulus("lock_body1", 5'b00010, 5'b00100, 1'b1, 5'b00001);
        clearReq();
        setReq(0, 2, flit(4'd0, 4'd2, 22'h0D02, T_SINGLE));
        setReq(1, 2, flit(4'd1, 4'd2, 22'h0D12, T_BODY));
        applyStimulus("lock_body2", 5'b00010, 5'b00100, 1'b1, 5'b00010);
        clearReq();
        setReq(0, 2, flit(4'd0, 4'd2, 22'h0D02, T_SINGLE));
        setReq(1, 2, flit(4'd1, 4'd2, 22'h0D13, T_TAIL));
        applyStimulus("lock_tail", 5'b00010, 5'b00100, 1'b1, 5'b00001);
        clearReq();
        setReq(0, 2, flit(4'd0, 4'd2, 22'h0D03, T_SINGLE));
        setReq(1, 2, flit(4'd1, 4'd2, 22'h0D14, T_SINGLE));
        applyStimulus("lock_after_tail", 5'b00001, 5'b00000, 1'b1, 5'b00010);

        // Reset in the middle of a packet on output 1 (pointer at 4).
        clearReq();
        setReq(2, 1, flit(4'd2, 4'd1, 22'h0E20, T_HEAD));
        applyStimulus("rst_head", 5'b00100, 5'b00000, 1'b0, 5'b00000);
        clearReq();
        setReq(2, 1, flit(4'd2, 4'd1, 22'h0E21, T_BODY));
        drive();
        #1;
        chk("rst_mid/locked", bus_lk.out_lock, 5'b00010);
        rst_n = 1'b0;
        #1;
        chk("rst_mid/out_lock",  bus_lk.out_lock,  '0);
        chk("rst_mid/out_valid", bus_lk.out_valid, '0);
        chk("rst_mid/in_ready",  bus_lk.in_ready,  '0);
        chk("rst_mid/out_data",  bus_lk.out_data,  '0);
        sb.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clearReq();
        setReq(4, 1, flit(4'd4, 4'd1, 22'h0E41, T_BODY));
        applyStimulus("post_rst_grant", 5'b10000, 5'b00000, 1'b1, 5'b10000);

        clearReq();
        drive();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
